// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, PC increment and fetch FSM state encoding for the fetch front end.
//   XLEN          - architectural register/address width
//   PC_INC        - sequential fetch stride in bytes
//   fetch_state_e - BOOT / REQ / WAIT sequencer states
package pc_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;
   typedef enum logic [1:0] {BOOT, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory req/gnt/rvalid handshake bundle.
//   req    - fetch request valid (fetch unit -> memory)
//   addr   - fetch address (fetch unit -> memory)
//   gnt    - request accepted this cycle (memory -> fetch unit)
//   rvalid - response data valid (memory -> fetch unit)
//   rdata  - instruction word (memory -> fetch unit)
interface pc_fetch_unit_if;
   import pc_pkg::*;
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;
   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/Adder.sv
// Adder: W-bit adder with carry-in; sum wraps modulo 2^W.
//   A, B - operands
//   C_in - carry-in
//   S    - sum
module Adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         C_in,
   output logic [W-1:0] S
);
   assign S = A + B + {{(W-1){1'b0}}, C_in};
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch sequencer.
//   clk, rst                  - clock, asynchronous active-high reset
//   stall_i                   - decode cannot accept; hold instruction output
//   redirect_i, redirect_pc_i - one-cycle redirect pulse and its target
//   imem                      - instruction-memory handshake (master side)
//   instr_valid_o, instr_o, instr_pc_o - fetched instruction to decode
//   misalign_o                - one-cycle pulse when redirect target was not word aligned
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [XLEN-1:0]        redirect_pc_i,
   pc_fetch_unit_if.master        imem,
   output logic                   instr_valid_o,
   output logic [XLEN-1:0]        instr_o,
   output logic [XLEN-1:0]        instr_pc_o,
   output logic                   misalign_o
);
   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pend_pc;
   logic [XLEN-1:0] pc_next;
   logic            kill;
   logic            fire;

   Adder #(.W(XLEN)) u_adder (
      .A   (pc),
      .B   (PC_INC),
      .C_in(1'b0),
      .S   (pc_next)
   );

   // No new request while a held instruction is blocked by decode.
   assign imem.req  = (state == REQ) && !(instr_valid_o && stall_i);
   assign imem.addr = pc;
   assign fire      = imem.req && imem.gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= BOOT;
         pc            <= RESET_PC;
         pend_pc       <= '0;
         kill          <= 1'b0;
         instr_valid_o <= 1'b0;
         instr_o       <= '0;
         instr_pc_o    <= '0;
         misalign_o    <= 1'b0;
      end else begin
         misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
         if (instr_valid_o && !stall_i) instr_valid_o <= 1'b0;
         if (redirect_i) begin
            pc            <= {redirect_pc_i[XLEN-1:2], 2'b00};
            instr_valid_o <= 1'b0;
            // A grant taken or a response pending now belongs to the old path.
            case (state)
               BOOT: state <= REQ;
               REQ: if (fire) begin
                  state <= WAIT;
                  kill  <= 1'b1;
               end
               WAIT: if (imem.rvalid) begin
                  state <= REQ;
                  kill  <= 1'b0;
               end else kill <= 1'b1;
               default: state <= BOOT;
            endcase
         end else begin
            case (state)
               BOOT: state <= REQ;
               REQ: if (fire) begin
                  pend_pc <= pc;
                  pc      <= pc_next;
                  state   <= WAIT;
               end
               WAIT: if (imem.rvalid) begin
                  state <= REQ;
                  if (kill) kill <= 1'b0;
                  else begin
                     instr_o       <= imem.rdata;
                     instr_pc_o    <= pend_pc;
                     instr_valid_o <= 1'b1;
                  end
               end
               default: state <= BOOT;
            endcase
         end
      end
   end
endmodule
